mips_trace_buffer: RTL and testbench
====================================

# mips_trace_buffer

Debug trace capture stage that sits directly downstream of the single-cycle MIPS core and consumes its per-cycle observation outputs: PC (`direccion`), fetched instruction (`palabra`) and write-back value (`leer_dato`). Once armed, it records one sample per clock into a circular buffer. It stops after a PC-match trigger plus a fixed post-trigger window, then replays the stored samples oldest-first over a valid/ready read port. Used for on-board bring-up of programs running on the core.

## Interface
- `DEPTH`, 16 — buffer entries; power of two, ≥ 2.
- `ADDR_W`, 4 — log2(`DEPTH`).
- `POST_TRIG`, 8 — samples captured after the trigger sample; legal range 0..`DEPTH`-1.

Ports:
- `clk` in 1 — single clock; everything is rising-edge.
- `rst` in 1 — reset, synchronous, active-high.
- `direccion` in 32 — core PC for the current cycle.
- `palabra` in 32 — core instruction word for the current cycle.
- `leer_dato` in 32 — core write-back data for the current cycle.
- `arm` in 1 — start capture; honoured only in IDLE.
- `trig_en` in 1 — 1: trigger on PC match; 0: trigger on the first ARMED cycle.
- `trig_pc` in 32 — PC value to match.
- `rd_ready` in 1 — consumer accepts the current read sample.
- `rd_valid` out 1 — read sample is valid.
- `rd_pc`, `rd_instr`, `rd_data` out 32 each — stored sample.
- `state` out 2 — 0 IDLE, 1 ARMED, 2 POST, 3 DUMP.
- `count` out `ADDR_W`+1 — number of stored valid samples, saturating at `DEPTH`.

## Operation
- Storage is a `DEPTH` x 96-bit array with write pointer `wr_ptr`, read pointer `rd_ptr`, post counter `post_cnt`, remaining counter `rem`.
- **IDLE:**
  - No writes; `rd_valid` = 0.
  - `arm` = 1 sets `wr_ptr` = 0 and `count` = 0, and moves to ARMED.
  - The sample present on the `arm` cycle is not stored.
- **ARMED:**
  - Each cycle, write {`direccion`, `palabra`, `leer_dato`} at `wr_ptr`, then `wr_ptr`++ (wraps mod `DEPTH`) and `count` = min(`count`+1, `DEPTH`).
  - When full, the oldest entry is overwritten.
  - Trigger = !`trig_en` || (`direccion` == `trig_pc`), evaluated on the same cycle's inputs.
  - The trigger sample is written.
  - On trigger, go to POST with `post_cnt` = `POST_TRIG`; if `POST_TRIG` == 0, go directly to DUMP.
- **POST:**
  - Write exactly as in ARMED, and decrement `post_cnt` on each write.
  - The write that brings `post_cnt` to 0 moves to DUMP.
  - The PC comparator is ignored in this state.
- **Entering DUMP:**
  - `rd_ptr` = (`wr_ptr` − `count`) mod `DEPTH`, computed from post-write values; this is the oldest stored sample.
  - `rem` = `count`.
- **DUMP:**
  - `rd_valid` = 1; `rd_*` = array[`rd_ptr`].
  - A transfer occurs when `rd_valid` && `rd_ready`; it does `rd_ptr`++ (wrap) and `rem`--.
  - The transfer with `rem` == 1 returns to IDLE.
  - No writes occur. `count` holds its value until the next arm.
- `arm` is ignored in ARMED, POST and DUMP.
- `count` is never 0 in DUMP: at least the trigger sample is always stored.

## Timing
- **Reset:**
  - `state` = IDLE; `count`, `wr_ptr`, `rd_ptr`, `post_cnt`, `rem` = 0.
  - `rd_valid` = 0; `rd_pc`, `rd_instr`, `rd_data` read 0. The array is cleared, or the `rd_*` outputs are gated to 0 outside DUMP.
  - `rst` overrides every other input in the same cycle.
  - Reset asserted mid-ARMED, mid-POST or mid-DUMP aborts to IDLE at the next edge; no partial dump resumes.
- **Capture latency:** inputs sampled at edge k are written at edge k. `count` reflects the write after edge k.
- The trigger sample and all `POST_TRIG` following core cycles are captured back-to-back, with no gaps.
- **First `rd_valid`:** the cycle immediately after the edge that performs the last POST write. With `POST_TRIG` = 0, it is the cycle after the trigger edge.
- **Read data:** combinational from the array at `rd_ptr`.
  - While `rd_valid` && !`rd_ready`, all `rd_*` outputs hold stable.
  - One transfer per cycle is sustainable with `rd_ready` held high.
- `rd_valid` falls in the cycle after the final transfer. `state` reads IDLE in that same cycle.
- **Arm latency:** `arm` at edge k means `state` = ARMED after k, and the first sample is stored at edge k+1.

## Test plan
- **Reset:** hold `rst` 2 cycles with random inputs → `state` = 0, `count` = 0, `rd_valid` = 0, `rd_*` = 0; `arm` asserted during `rst` is ignored.
- **Immediate trigger:** `trig_en` = 0, `POST_TRIG` = 8, PC = 0x100, 0x104, … from the first ARMED cycle.
  - Expected: DUMP after 9 writes, `count` = 9.
  - Dump yields PCs 0x100..0x120 in order with matching `palabra`/`leer_dato`, then `state` = IDLE.
- **Wrap:** `DEPTH` = 16, `trig_en` = 1, `trig_pc` = 0x40, PC = 0x00, 0x04, … from the first ARMED cycle.
  - Expected: 25 writes, `count` = 16.
  - Dump yields exactly the PCs 0x24..0x60 in ascending order.
- **Backpressure:** during DUMP, hold `rd_ready` = 0 for 5 cycles, then toggle it every cycle.
  - Expected: `rd_valid` stays 1 and `rd_*` hold stable while stalled; each sample is delivered exactly once; no sample is skipped or duplicated.
- **Arm ignored / reset abort:** pulse `arm` during POST and during DUMP → no effect on pointers or state. Assert `rst` on the 3rd POST cycle → IDLE next cycle, `count` = 0, `rd_valid` never rises.
- **Non-matching PC:** `trig_en` = 1 with `trig_pc` never presented for 40 cycles → remains ARMED with `count` = 16. Presenting `trig_pc` afterward triggers normally.

Source files
------------

// File: rtl/mips_trace_buffer.sv
// ---------------------------------------------------------------------------
// mips_trace_buffer
//
// Debug trace capture for the single-cycle MIPS core. After arming, one
// {PC, instruction, write-back data} sample is recorded per clock into a
// circular buffer. Capture stops a fixed number of samples after a trigger.
// The stored samples are then replayed oldest-first over a valid/ready port.
//
// Parameters:
//   DEPTH     - buffer entries (power of two, >= 2)
//   ADDR_W    - log2(DEPTH)
//   POST_TRIG - samples captured after the trigger sample (0..DEPTH-1)
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   direccion         - core PC for the current cycle
//   palabra           - core instruction word for the current cycle
//   leer_dato         - core write-back data for the current cycle
//   arm               - start a capture (honoured only in IDLE)
//   trig_en, trig_pc  - 1: trigger on PC == trig_pc, 0: trigger immediately
//   rd_ready          - consumer accepts the current read sample
//   rd_valid          - read sample valid (DUMP state)
//   rd_pc/instr/data  - replayed sample, forced to 0 outside DUMP
//   state             - 0 IDLE, 1 ARMED, 2 POST, 3 DUMP
//   count             - stored valid samples, saturating at DEPTH
// ---------------------------------------------------------------------------
module mips_trace_buffer #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int POST_TRIG = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       direccion,
   input  logic [31:0]       palabra,
   input  logic [31:0]       leer_dato,
   input  logic              arm,
   input  logic              trig_en,
   input  logic [31:0]       trig_pc,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [31:0]       rd_pc,
   output logic [31:0]       rd_instr,
   output logic [31:0]       rd_data,
   output logic [1:0]        state,
   output logic [ADDR_W:0]   count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DUMP  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0]   FULL      = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_TRIG);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [ADDR_W:0]     rem_q, rem_d;

   logic [95:0]         mem [DEPTH];
   logic [95:0]         rd_word;

   logic                capture;
   logic                trigger;
   logic [ADDR_W-1:0]   wr_ptr_inc;
   logic [ADDR_W:0]     count_inc;

   always_comb begin
      capture    = (state_q == S_ARMED) || (state_q == S_POST);
      trigger    = !trig_en || (direccion == trig_pc);
      wr_ptr_inc = wr_ptr_q + ADDR_W'(1);
      count_inc  = (count_q == FULL) ? count_q : count_q + (ADDR_W+1)'(1);

      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      post_cnt_d = post_cnt_q;
      count_d    = count_q;
      rem_d      = rem_q;

      case (state_q)
         S_IDLE: begin
            if (arm) begin
               state_d  = S_ARMED;
               wr_ptr_d = '0;
               count_d  = '0;
            end
         end
         S_ARMED: begin
            wr_ptr_d = wr_ptr_inc;
            count_d  = count_inc;
            if (trigger) begin
               if (POST_TRIG == 0) begin
                  // Oldest sample sits count entries behind the post-write
                  // pointer; when full, the low bits of count are 0 and the
                  // oldest entry is the one about to be overwritten next.
                  state_d  = S_DUMP;
                  rd_ptr_d = wr_ptr_inc - count_inc[ADDR_W-1:0];
                  rem_d    = count_inc;
               end else begin
                  state_d    = S_POST;
                  post_cnt_d = POST_INIT;
               end
            end
         end
         S_POST: begin
            wr_ptr_d   = wr_ptr_inc;
            count_d    = count_inc;
            post_cnt_d = post_cnt_q - ADDR_W'(1);
            if (post_cnt_q == ADDR_W'(1)) begin
               state_d  = S_DUMP;
               rd_ptr_d = wr_ptr_inc - count_inc[ADDR_W-1:0];
               rem_d    = count_inc;
            end
         end
         S_DUMP: begin
            if (rd_ready) begin
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               rem_d    = rem_q - (ADDR_W+1)'(1);
               if (rem_q == (ADDR_W+1)'(1)) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         post_cnt_q <= '0;
         count_q    <= '0;
         rem_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         post_cnt_q <= post_cnt_d;
         count_q    <= count_d;
         rem_q      <= rem_d;
      end
   end

   // Sample storage carries no reset; stale contents are hidden by the
   // output gating below.
   always_ff @(posedge clk) begin
      if (capture && !rst) begin
         mem[wr_ptr_q] <= {direccion, palabra, leer_dato};
      end
   end

   always_comb begin
      rd_valid = (state_q == S_DUMP);
      rd_word  = mem[rd_ptr_q];
      rd_pc    = rd_valid ? rd_word[95:64] : 32'd0;
      rd_instr = rd_valid ? rd_word[63:32] : 32'd0;
      rd_data  = rd_valid ? rd_word[31:0]  : 32'd0;
      state    = state_q;
      count    = count_q;
   end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_mips_trace_buffer
//
// Self-checking bench for mips_trace_buffer. A reference model keeps the
// captured samples in a queue trimmed to DEPTH entries and tracks the
// trigger / post-trigger window with plain counters; the dump is expected to
// replay that queue front to back.
// ---------------------------------------------------------------------------
module tb_mips_trace_buffer;

   localparam int DEPTH     = 16;
   localparam int ADDR_W    = 4;
   localparam int POST_TRIG = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       direccion, palabra, leer_dato, trig_pc;
   logic              arm, trig_en, rd_ready;
   logic              rd_valid;
   logic [31:0]       rd_pc, rd_instr, rd_data;
   logic [1:0]        state;
   logic [ADDR_W:0]   count;

   int tests = 0;
   int fails = 0;

   logic [95:0] q[$];

   typedef struct {
      bit          ten;
      logic [31:0] tpc;
      int          mode;
      logic [31:0] base;
      int          exp_count;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   vec_t tbl[4];

   mips_trace_buffer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .POST_TRIG(POST_TRIG)
   ) dut (
      .clk(clk), .rst(rst),
      .direccion(direccion), .palabra(palabra), .leer_dato(leer_dato),
      .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
      .rd_ready(rd_ready), .rd_valid(rd_valid),
      .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_data(rd_data),
      .state(state), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_core;
      direccion = $urandom;
      palabra   = $urandom;
      leer_dato = $urandom;
   endtask

   // Arms the DUT and feeds samples until the model says the capture window
   // is complete. mode 0: PC = base + 4*i; mode 1: random PC, trig_pc
   // presented about 1 in 8 cycles; mode 2: PC = base + 4*i except trig_pc
   // at i = 40.
   task automatic capture_run(input bit ten, input logic [31:0] tpc, input int mode,
                              input logic [31:0] base, input bit arm_noise, output bit ok);
      bit          trig;
      int          left;
      bit          done;
      logic [31:0] pc;
      logic [95:0] s;
      q.delete();
      ok      = 1'b0;
      trig    = 1'b0;
      left    = 0;
      trig_en = ten;
      trig_pc = tpc;
      arm     = 1'b1;
      rand_core();
      tick();
      chk("arm_state", state, 1);
      chk("arm_count", count, 0);
      for (int i = 0; i < 300; i++) begin
         if (mode == 0)      pc = base + 32'(4 * i);
         else if (mode == 2) pc = (i == 40) ? tpc : base + 32'(4 * i);
         else                pc = ($urandom_range(0, 7) == 0) ? tpc : $urandom;
         s = {pc, 32'($urandom), 32'($urandom)};
         direccion = s[95:64];
         palabra   = s[63:32];
         leer_dato = s[31:0];
         arm       = arm_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         q.push_back(s);
         if (q.size() > DEPTH) void'(q.pop_front());
         if (!trig) begin
            if (!ten || pc == tpc) begin
               trig = 1'b1;
               left = POST_TRIG;
            end
         end else begin
            left--;
         end
         done = trig && (left == 0);
         tick();
         chk("cap_state", state, done ? 3 : (trig ? 2 : 1));
         chk("cap_count", count, q.size());
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      arm = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL cap_timeout: got no DUMP, expected DUMP within 300 cycles");
      end
   endtask

   // rmode 0: rd_ready always 1; 1: stalled 5 cycles then toggling;
   // 2: random.
   task automatic drain(input int rmode, input bit arm_noise, output logic [31:0] last_pc);
      last_pc = 32'd0;
      for (int c = 0; c < 300 && q.size() > 0; c++) begin
         if (rmode == 0)      rd_ready = 1'b1;
         else if (rmode == 1) rd_ready = (c < 5) ? 1'b0 : (c % 2 == 1);
         else                 rd_ready = 1'($urandom_range(0, 1));
         arm = arm_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         rand_core();
         chk("rd_valid", rd_valid, 1);
         chk("rd_sample", {rd_pc, rd_instr, rd_data}, q[0]);
         if (rd_ready) begin
            last_pc = q[0][95:64];
            void'(q.pop_front());
         end
         tick();
      end
      arm      = 1'b0;
      rd_ready = 1'b0;
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d samples left, expected 0", q.size());
      end
      chk("end_valid", rd_valid, 0);
      chk("end_state", state, 0);
      chk("end_rd_zero", {rd_pc, rd_instr, rd_data}, 96'd0);
   endtask

   task automatic recover;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bit          ok;
      logic [31:0] last;

      tbl[0] = '{ten: 1'b0, tpc: 32'h0,        mode: 0, base: 32'h100,
                 exp_count: 9,  exp_first: 32'h100,  exp_last: 32'h120};
      tbl[1] = '{ten: 1'b1, tpc: 32'h40,       mode: 0, base: 32'h0,
                 exp_count: 16, exp_first: 32'h24,   exp_last: 32'h60};
      tbl[2] = '{ten: 1'b1, tpc: 32'hDEAD0000, mode: 2, base: 32'h1000,
                 exp_count: 16, exp_first: 32'h1084, exp_last: 32'h10C0};
      tbl[3] = '{ten: 1'b1, tpc: 32'h208,      mode: 0, base: 32'h200,
                 exp_count: 11, exp_first: 32'h200,  exp_last: 32'h228};

      // Reset with arm held and random core activity.
      rst      = 1'b1;
      arm      = 1'b1;
      trig_en  = 1'b0;
      trig_pc  = $urandom;
      rd_ready = 1'b1;
      rand_core();
      tick();
      rand_core();
      tick();
      chk("rst_state", state, 0);
      chk("rst_count", count, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_rd_zero", {rd_pc, rd_instr, rd_data}, 96'd0);
      rst      = 1'b0;
      arm      = 1'b0;
      rd_ready = 1'b0;
      tick();
      chk("post_rst_idle", state, 0);

      // Directed capture scenarios.
      for (int t = 0; t < 4; t++) begin
         capture_run(tbl[t].ten, tbl[t].tpc, tbl[t].mode, tbl[t].base, 1'b0, ok);
         if (!ok) begin
            recover();
            continue;
         end
         chk("tbl_count", count, tbl[t].exp_count);
         chk("tbl_first_pc", rd_pc, tbl[t].exp_first);
         drain(0, 1'b0, last);
         chk("tbl_last_pc", last, tbl[t].exp_last);
      end

      // Backpressure with arm pulses during ARMED/POST/DUMP.
      capture_run(1'b0, 32'h0, 0, 32'h300, 1'b1, ok);
      if (ok) begin
         chk("bp_count", count, 9);
         drain(1, 1'b1, last);
         chk("bp_last_pc", last, 32'h320);
      end else begin
         recover();
      end

      // Reset on the third POST cycle aborts the capture.
      trig_en = 1'b0;
      arm     = 1'b1;
      rand_core();
      tick();
      arm = 1'b0;
      rand_core();
      tick();
      chk("abort_post1", state, 2);
      rand_core();
      tick();
      rand_core();
      tick();
      chk("abort_post3", state, 2);
      rst = 1'b1;
      rand_core();
      tick();
      rst = 1'b0;
      chk("abort_state", state, 0);
      chk("abort_count", count, 0);
      for (int c = 0; c < 20; c++) begin
         rand_core();
         rd_ready = 1'($urandom_range(0, 1));
         tick();
         chk("abort_no_valid", rd_valid, 0);
      end
      rd_ready = 1'b0;

      // Randomized captures against the model.
      for (int r = 0; r < 6; r++) begin
         capture_run(1'($urandom_range(0, 1)), $urandom, 1, 32'h0, 1'($urandom_range(0, 1)), ok);
         if (!ok) begin
            recover();
            continue;
         end
         drain(2, 1'($urandom_range(0, 1)), last);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
